// File: rtl/prog_loader.sv
// prog_loader: strobe-driven program memory loader for the accumulator CPU.
// Captures up to DEPTH instruction bytes from slow asynchronous pins into a
// register-file program memory, serves combinational fetches, and holds the
// core in reset while a program is being loaded.
module prog_loader #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_mode,
  input  logic       strobe,
  input  logic [7:0] data_in,
  input  logic [3:0] fetch_addr,
  output logic [7:0] instr,
  output logic       cpu_rst_n,
  output logic       running,
  output logic [4:0] count,
  output logic       overflow,
  output logic [7:0] checksum
);

  localparam logic [4:0] FULL = 5'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t      state_q, state_d;

  // synchroniser chains for the asynchronous pins
  logic        lm_s1_q, lm_s_q;
  logic        st_s1_q, st_s_q, st_d_q;

  logic [7:0]  mem_q [DEPTH];
  logic [4:0]  count_q;
  logic [7:0]  checksum_q;
  logic        overflow_q;
  logic        cpu_rst_n_q;

  logic        wr_pulse;
  logic        do_write;
  logic        do_ovf;
  logic        do_clear;
  logic        cpu_rst_n_d;

  // two-flop synchronisers plus strobe edge-detect delay flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lm_s1_q <= 1'b0;
      lm_s_q  <= 1'b0;
      st_s1_q <= 1'b0;
      st_s_q  <= 1'b0;
      st_d_q  <= 1'b0;
    end else begin
      lm_s1_q <= load_mode;
      lm_s_q  <= lm_s1_q;
      st_s1_q <= strobe;
      st_s_q  <= st_s1_q;
      st_d_q  <= st_s_q;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = lm_s_q ? LOAD : RUN;
      LOAD:    if (!lm_s_q) state_d = RUN;
      RUN:     if (lm_s_q)  state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: write/overflow/clear strobes and next core-reset level
  always_comb begin
    wr_pulse    = st_s_q & ~st_d_q & (state_q == LOAD);
    do_write    = wr_pulse && (count_q < FULL);
    do_ovf      = wr_pulse && (count_q == FULL);
    // entering LOAD from anywhere else starts a fresh session
    do_clear    = (state_q != LOAD) && (state_d == LOAD);
    cpu_rst_n_d = (state_d == RUN);
  end

  // registered core reset, changes on the same edge as the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rst_n_q <= 1'b0;
    end else begin
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

  // session counters: byte count, running checksum, overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      checksum_q <= '0;
      overflow_q <= 1'b0;
    end else if (do_clear) begin
      count_q    <= '0;
      checksum_q <= '0;
      overflow_q <= 1'b0;
    end else if (do_write) begin
      count_q    <= count_q + 5'd1;
      checksum_q <= checksum_q + data_in;
    end else if (do_ovf) begin
      overflow_q <= 1'b1;
    end
  end

  // program memory: cleared by reset, retained across reloads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_write) begin
      mem_q[count_q[3:0]] <= data_in;
    end
  end

  assign instr     = mem_q[fetch_addr];
  assign cpu_rst_n = cpu_rst_n_q;
  assign running   = (state_q == RUN);
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign checksum  = checksum_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized self-checking bench for prog_loader with a
// session-level reference model of the program memory and counters.
module tb_prog_loader;

  logic       clk;
  logic       rst_n;
  logic       load_mode;
  logic       strobe;
  logic [7:0] data_in;
  logic [3:0] fetch_addr;
  logic [7:0] instr;
  logic       cpu_rst_n;
  logic       running;
  logic [4:0] count;
  logic       overflow;
  logic [7:0] checksum;

  int n_cmp;
  int n_err;

  // reference model
  logic [7:0] m_mem [16];
  int         m_count;
  logic [7:0] m_sum;
  logic       m_ovf;
  logic       m_loading;

  prog_loader #(.DEPTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_mode  (load_mode),
    .strobe     (strobe),
    .data_in    (data_in),
    .fetch_addr (fetch_addr),
    .instr      (instr),
    .cpu_rst_n  (cpu_rst_n),
    .running    (running),
    .count      (count),
    .overflow   (overflow),
    .checksum   (checksum)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_count   = 0;
    m_sum     = 8'h00;
    m_ovf     = 1'b0;
    m_loading = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_loading) begin
      if (m_count < 16) begin
        m_mem[m_count] = b;
        m_count++;
        m_sum = m_sum + b;
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  // one full strobe cycle, data held throughout
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    data_in = b;
    strobe  = 1'b1;
    repeat (4) @(negedge clk);
    strobe  = 1'b0;
    repeat (4) @(negedge clk);
    model_byte(b);
  endtask

  task automatic set_load(input logic v);
    @(negedge clk);
    load_mode = v;
    repeat (5) @(negedge clk);
    if (v && !m_loading) begin
      m_count = 0;
      m_sum   = 8'h00;
      m_ovf   = 1'b0;
    end
    m_loading = v;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int a = 0; a < 16; a++) begin
      fetch_addr = 4'(a);
      #1;
      n_cmp++;
      if (instr !== 8'h00) begin
        n_err++;
        $display("FAIL reset_instr[%0d]: got %h want 00", a, instr);
      end
    end
    n_cmp++;
    if (cpu_rst_n !== 1'b0 || running !== 1'b0 || count !== 5'd0 ||
        checksum !== 8'h00 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got cpu_rst_n=%b running=%b count=%0d sum=%h ovf=%b want 0/0/0/00/0",
               cpu_rst_n, running, count, checksum, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (5) @(negedge clk);
    n_cmp++;
    if (running !== 1'b1 || cpu_rst_n !== 1'b1) begin
      n_err++;
      $display("FAIL reset_to_run: got running=%b cpu_rst_n=%b want 1/1", running, cpu_rst_n);
    end
  endtask

  task automatic test_basic_load();
    logic [7:0] bytes [3];
    bytes[0] = 8'h13; bytes[1] = 8'h22; bytes[2] = 8'h60;
    set_load(1'b1);
    n_cmp++;
    if (cpu_rst_n !== 1'b0 || running !== 1'b0) begin
      n_err++;
      $display("FAIL basic_enter_load: got cpu_rst_n=%b running=%b want 0/0", cpu_rst_n, running);
    end
    // first byte: check exact strobe-to-write latency
    @(negedge clk);
    data_in = bytes[0];
    strobe  = 1'b1;
    @(posedge clk); #1;   // edge k
    @(posedge clk); #1;   // edge k+1
    n_cmp++;
    if (count !== 5'd0) begin
      n_err++;
      $display("FAIL basic_latency_early: got count=%0d want 0", count);
    end
    @(posedge clk); #1;   // edge k+2
    n_cmp++;
    if (count !== 5'd1) begin
      n_err++;
      $display("FAIL basic_latency_write: got count=%0d want 1", count);
    end
    repeat (3) @(negedge clk);
    strobe = 1'b0;
    repeat (4) @(negedge clk);
    model_byte(bytes[0]);
    send_byte(bytes[1]);
    send_byte(bytes[2]);
    // release load_mode and time the core-reset release
    @(negedge clk);
    load_mode = 1'b0;
    @(posedge clk); #1;   // edge k
    @(posedge clk); #1;   // edge k+1
    n_cmp++;
    if (cpu_rst_n !== 1'b0) begin
      n_err++;
      $display("FAIL basic_cpu_rst_early: got %b want 0", cpu_rst_n);
    end
    @(posedge clk); #1;   // edge k+2
    n_cmp++;
    if (cpu_rst_n !== 1'b1 || running !== 1'b1) begin
      n_err++;
      $display("FAIL basic_cpu_rst_rise: got cpu_rst_n=%b running=%b want 1/1", cpu_rst_n, running);
    end
    m_loading = 1'b0;
    @(negedge clk);
    for (int a = 0; a < 3; a++) begin
      fetch_addr = 4'(a);
      #1;
      n_cmp++;
      if (instr !== bytes[a]) begin
        n_err++;
        $display("FAIL basic_mem[%0d]: got %h want %h", a, instr, bytes[a]);
      end
    end
    n_cmp++;
    if (count !== 5'd3 || checksum !== 8'h95 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL basic_counters: got count=%0d sum=%h ovf=%b want 3/95/0", count, checksum, overflow);
    end
  endtask

  task automatic test_reload();
    set_load(1'b1);
    n_cmp++;
    if (cpu_rst_n !== 1'b0 || count !== 5'd0 || checksum !== 8'h00) begin
      n_err++;
      $display("FAIL reload_pre_write: got cpu_rst_n=%b count=%0d sum=%h want 0/0/00", cpu_rst_n, count, checksum);
    end
    send_byte(8'h55);
    set_load(1'b0);
    fetch_addr = 4'd0; #1;
    n_cmp++;
    if (instr !== 8'h55) begin
      n_err++;
      $display("FAIL reload_mem0: got %h want 55", instr);
    end
    fetch_addr = 4'd1; #1;
    n_cmp++;
    if (instr !== 8'h22) begin
      n_err++;
      $display("FAIL reload_mem1_retained: got %h want 22", instr);
    end
    n_cmp++;
    if (count !== 5'd1 || checksum !== 8'h55 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL reload_counters: got count=%0d sum=%h ovf=%b want 1/55/0", count, checksum, overflow);
    end
  endtask

  task automatic test_ignored_strobe();
    send_byte(8'hAA);
    @(negedge clk);
    for (int a = 0; a < 16; a++) begin
      fetch_addr = 4'(a);
      #1;
      n_cmp++;
      if (instr !== m_mem[a]) begin
        n_err++;
        $display("FAIL ignored_mem[%0d]: got %h want %h", a, instr, m_mem[a]);
      end
    end
    n_cmp++;
    if (count !== 5'(m_count) || running !== 1'b1) begin
      n_err++;
      $display("FAIL ignored_count: got count=%0d running=%b want %0d/1", count, running, m_count);
    end
  endtask

  task automatic test_overflow();
    set_load(1'b1);
    for (int i = 0; i < 16; i++) send_byte(8'h01);
    send_byte(8'hEE);
    @(negedge clk);
    n_cmp++;
    if (count !== 5'd16 || checksum !== 8'h10 || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL overflow_counters: got count=%0d sum=%h ovf=%b want 16/10/1", count, checksum, overflow);
    end
    fetch_addr = 4'd15; #1;
    n_cmp++;
    if (instr !== 8'h01) begin
      n_err++;
      $display("FAIL overflow_mem15: got %h want 01", instr);
    end
    fetch_addr = 4'd0; #1;
    n_cmp++;
    if (instr !== 8'h01) begin
      n_err++;
      $display("FAIL overflow_no_wrap: got %h want 01", instr);
    end
    set_load(1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int nb;
      set_load(1'b1);
      nb = int'($urandom_range(0, 19));
      for (int i = 0; i < nb; i++) send_byte(8'($urandom));
      if ($urandom_range(0, 1) == 1) send_byte(8'($urandom));
      set_load(1'b0);
      if ($urandom_range(0, 1) == 1) send_byte(8'($urandom));
      @(negedge clk);
      for (int a = 0; a < 16; a++) begin
        fetch_addr = 4'(a);
        #1;
        n_cmp++;
        if (instr !== m_mem[a]) begin
          n_err++;
          $display("FAIL random%0d_mem[%0d]: got %h want %h", r, a, instr, m_mem[a]);
        end
      end
      n_cmp++;
      if (count !== 5'(m_count) || checksum !== m_sum || overflow !== m_ovf || running !== 1'b1) begin
        n_err++;
        $display("FAIL random%0d_counters: got count=%0d sum=%h ovf=%b run=%b want %0d/%h/%b/1",
                 r, count, checksum, overflow, running, m_count, m_sum, m_ovf);
      end
    end
  endtask

  task automatic test_mid_load_reset();
    logic [7:0] b2, b3;
    set_load(1'b1);
    send_byte(8'($urandom));
    send_byte(8'($urandom));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int a = 0; a < 16; a++) begin
      fetch_addr = 4'(a);
      #1;
      n_cmp++;
      if (instr !== 8'h00) begin
        n_err++;
        $display("FAIL midreset_mem[%0d]: got %h want 00", a, instr);
      end
    end
    n_cmp++;
    if (running !== 1'b0 || cpu_rst_n !== 1'b0 || count !== 5'd0) begin
      n_err++;
      $display("FAIL midreset_state: got run=%b cpu_rst_n=%b count=%0d want 0/0/0", running, cpu_rst_n, count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    m_loading = 1'b1;
    n_cmp++;
    if (running !== 1'b0 || cpu_rst_n !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_reload: got run=%b cpu_rst_n=%b want 0/0", running, cpu_rst_n);
    end
    b2 = 8'($urandom);
    b3 = 8'($urandom);
    send_byte(b2);
    send_byte(b3);
    @(negedge clk);
    for (int a = 0; a < 16; a++) begin
      fetch_addr = 4'(a);
      #1;
      n_cmp++;
      if (instr !== m_mem[a]) begin
        n_err++;
        $display("FAIL midreset_after[%0d]: got %h want %h", a, instr, m_mem[a]);
      end
    end
    n_cmp++;
    if (count !== 5'd2 || checksum !== 8'(b2 + b3)) begin
      n_err++;
      $display("FAIL midreset_counters: got count=%0d sum=%h want 2/%h", count, checksum, 8'(b2 + b3));
    end
    set_load(1'b0);
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    load_mode  = 1'b0;
    strobe     = 1'b0;
    data_in    = 8'h00;
    fetch_addr = 4'd0;
    model_reset();
    test_reset();
    test_basic_load();
    test_reload();
    test_ignored_strobe();
    test_overflow();
    test_random();
    test_mid_load_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
